intr_sig_recv: RTL and testbench

// Receiving end of the peripheral interrupt-signal protocol: collects N_SRC interrupt lines driven by

---
 rtl/intr_sig_recv_pkg.sv | 19 +
 rtl/intr_src_detect.sv | 63 ++++++
 rtl/intr_sig_recv.sv | 106 ++++++++++
 tb/tb_intr_sig_recv.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/intr_sig_recv_pkg.sv
// Shared types for the interrupt-signal receiver: trigger qualification modes,
// the handshake FSM state type and the elaboration error text.
package intr_sig_recv_pkg;

  typedef enum logic [1:0] {
    INTR_EDGE_TRIG  = 2'd0,
    INTR_PULSE_TRIG = 2'd1,
    INTR_LEVEL_TRIG = 2'd2
  } intr_trigger_type;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } intr_recv_state_t;

  localparam string ErrorIntr = "ErrorIntr: unsupported INTR_TRIG value";

endpackage

// File: rtl/intr_src_detect.sv
// Per-source front end: registers the line, qualifies it per trigger mode and
// holds the pending and sticky short-pulse error bits.
module intr_src_detect
  import intr_sig_recv_pkg::*;
#(
  parameter intr_trigger_type TRIG      = INTR_PULSE_TRIG,
  parameter int unsigned      MIN_PULSE = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  input  logic clr_i,
  input  logic err_clr_i,
  output logic pending_o,
  output logic err_o
);

  localparam int unsigned     CW       = $clog2(MIN_PULSE + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(MIN_PULSE);
  localparam logic [CW-1:0]   CNT_QUAL = CW'(MIN_PULSE - 1);

  logic          sig_q;
  logic          pend_q, pend_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise, fall, set, short_pulse;

  always_comb begin
    rise        = sig_i & ~sig_q;
    fall        = ~sig_i & sig_q;
    cnt_d       = '0;
    set         = 1'b0;
    short_pulse = 1'b0;
    if (TRIG == INTR_PULSE_TRIG) begin
      if (sig_i) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      set = sig_i && (cnt_q == CNT_QUAL);
      // cnt saturates at MIN_PULSE, so anything below it at the fall was too short
      short_pulse = fall && (cnt_q != CNT_MAX);
    end else if (TRIG == INTR_EDGE_TRIG) begin
      set = rise;
    end
    pend_d = set | (pend_q & ~clr_i);
    err_d  = short_pulse | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sig_q  <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sig_q  <= sig_i;
      pend_q <= pend_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pending_o = (TRIG == INTR_LEVEL_TRIG) ? sig_q : pend_q;
  assign err_o     = err_q;

endmodule

// File: rtl/intr_sig_recv.sv
// Interrupt receiver top: per-source detection, lowest-index priority encoder
// and the req/ack handshake toward the CPU side.
module intr_sig_recv
  import intr_sig_recv_pkg::*;
#(
  parameter  int unsigned      N_SRC     = 8,
  parameter  intr_trigger_type INTR_TRIG = INTR_PULSE_TRIG,
  parameter  int unsigned      MIN_PULSE = 10,
  localparam int unsigned      ID_BW     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_SRC-1:0] i_intr_sig,
  input  logic [N_SRC-1:0] i_mask,
  output logic             o_irq,
  output logic [ID_BW-1:0] o_irq_id,
  input  logic             i_ack,
  output logic [N_SRC-1:0] o_pending,
  output logic [N_SRC-1:0] o_err_short,
  input  logic             i_err_clr
);

  if (INTR_TRIG != INTR_EDGE_TRIG && INTR_TRIG != INTR_PULSE_TRIG &&
      INTR_TRIG != INTR_LEVEL_TRIG) begin : g_bad_trig
    $error(ErrorIntr);
  end

  logic [N_SRC-1:0] pend, clr, cand;
  logic [ID_BW-1:0] winner, id_q, id_d;
  logic             found, id_line, irq_q, irq_d;
  intr_recv_state_t state_q, state_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    intr_src_detect #(
      .TRIG      (INTR_TRIG),
      .MIN_PULSE (MIN_PULSE)
    ) u_det (
      .clk_i     (i_clk),
      .rst_i     (i_rst),
      .sig_i     (i_intr_sig[g]),
      .clr_i     (clr[g]),
      .err_clr_i (i_err_clr),
      .pending_o (pend[g]),
      .err_o     (o_err_short[g])
    );
  end

  always_comb begin
    cand    = pend & ~i_mask;
    winner  = '0;
    found   = 1'b0;
    id_line = 1'b0;
    clr     = '0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (cand[i] && !found) begin
        winner = ID_BW'(i);
        found  = 1'b1;
      end
      if (id_q == ID_BW'(i)) id_line = pend[i];
    end

    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
          id_d    = winner;
        end
      end
      ST_REQ: begin
        if (i_ack) begin
          irq_d = 1'b0;
          if (INTR_TRIG == INTR_LEVEL_TRIG) begin
            state_d = ST_WAIT;
          end else begin
            state_d = ST_IDLE;
            for (int unsigned i = 0; i < N_SRC; i++) clr[i] = (id_q == ID_BW'(i));
          end
        end
      end
      // level pending mirrors the registered line, so this waits for it to drop
      ST_WAIT: if (!id_line) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      irq_q   <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      id_q    <= id_d;
    end
  end

  assign o_irq     = irq_q;
  assign o_irq_id  = id_q;
  assign o_pending = pend;

endmodule

// File: tb/tb_intr_sig_recv.sv
// Directed bench for intr_sig_recv: one instance per trigger mode, a vector
// table for the edge-mode handshake plus hand-written pulse/level/reset sequences.
module tb_intr_sig_recv;
  import intr_sig_recv_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] e_sig, e_mask, e_pend, e_err;
  logic       e_ack, e_errclr, e_irq;
  logic [2:0] e_id;
  logic [7:0] p_sig, p_mask, p_pend, p_err;
  logic       p_ack, p_errclr, p_irq;
  logic [2:0] p_id;
  logic [7:0] l_sig, l_mask, l_pend, l_err;
  logic       l_ack, l_errclr, l_irq;
  logic [2:0] l_id;

  intr_sig_recv #(.N_SRC(8), .INTR_TRIG(INTR_EDGE_TRIG), .MIN_PULSE(10)) u_edge (
    .i_clk(clk), .i_rst(rst), .i_intr_sig(e_sig), .i_mask(e_mask), .o_irq(e_irq),
    .o_irq_id(e_id), .i_ack(e_ack), .o_pending(e_pend), .o_err_short(e_err),
    .i_err_clr(e_errclr));

  intr_sig_recv #(.N_SRC(8), .INTR_TRIG(INTR_PULSE_TRIG), .MIN_PULSE(10)) u_pulse (
    .i_clk(clk), .i_rst(rst), .i_intr_sig(p_sig), .i_mask(p_mask), .o_irq(p_irq),
    .o_irq_id(p_id), .i_ack(p_ack), .o_pending(p_pend), .o_err_short(p_err),
    .i_err_clr(p_errclr));

  intr_sig_recv #(.N_SRC(8), .INTR_TRIG(INTR_LEVEL_TRIG), .MIN_PULSE(10)) u_level (
    .i_clk(clk), .i_rst(rst), .i_intr_sig(l_sig), .i_mask(l_mask), .o_irq(l_irq),
    .o_irq_id(l_id), .i_ack(l_ack), .o_pending(l_pend), .o_err_short(l_err),
    .i_err_clr(l_errclr));

  int unsigned n_pass = 0;
  int unsigned n_tot  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lvl_irq(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (l_irq) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] sig;
    logic [7:0] mask;
    logic       ack;
    logic       care;
    logic       irq;
    logic [2:0] id;
    logic [7:0] pend;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    rst = 1'b1;
    e_sig = '0; e_mask = '0; e_ack = 1'b0; e_errclr = 1'b0;
    p_sig = '0; p_mask = '0; p_ack = 1'b0; p_errclr = 1'b0;
    l_sig = '0; l_mask = '0; l_ack = 1'b0; l_errclr = 1'b0;

    // Edge-mode vectors: inputs held for one cycle, outputs sampled after that edge
    tbl[0]  = '{8'h08, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h08};
    tbl[1]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08};
    tbl[2]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08};
    tbl[3]  = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[4]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[5]  = '{8'h24, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h24};
    tbl[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd2, 8'h24};
    tbl[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h20};
    tbl[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20};
    tbl[9]  = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[10] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[11] = '{8'h10, 8'h10, 1'b0, 1'b1, 1'b0, 3'd0, 8'h10};
    tbl[12] = '{8'h00, 8'h10, 1'b0, 1'b1, 1'b0, 3'd0, 8'h10};
    tbl[13] = '{8'h00, 8'h10, 1'b0, 1'b1, 1'b0, 3'd0, 8'h10};
    tbl[14] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h10};
    tbl[15] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10};
    tbl[16] = '{8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h10};
    tbl[17] = '{8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h10};
    tbl[18] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};
    tbl[19] = '{8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00};

    tick(); tick();
    rst = 1'b0;
    check("rst_edge_irq", {31'd0, e_irq}, 32'd0);
    check("rst_edge_id", {29'd0, e_id}, 32'd0);
    check("rst_edge_pend", {24'd0, e_pend}, 32'd0);
    check("rst_pulse_err", {24'd0, p_err}, 32'd0);
    check("rst_level_irq", {31'd0, l_irq}, 32'd0);

    for (int k = 0; k < 20; k++) begin
      e_sig = tbl[k].sig; e_mask = tbl[k].mask; e_ack = tbl[k].ack;
      tick();
      if (tbl[k].care) begin
        check($sformatf("edge_irq[%0d]", k), {31'd0, e_irq}, {31'd0, tbl[k].irq});
        if (tbl[k].irq) check($sformatf("edge_id[%0d]", k), {29'd0, e_id}, {29'd0, tbl[k].id});
      end
      check($sformatf("edge_pend[%0d]", k), {24'd0, e_pend}, {24'd0, tbl[k].pend});
    end
    e_sig = '0; e_mask = '0; e_ack = 1'b0;

    // Pulse mode: 10-cycle pulse on src1 qualifies on its 10th high cycle
    p_sig = 8'h02;
    for (int i = 0; i < 9; i++) tick();
    check("pulse_pend_9cyc", {24'd0, p_pend}, 32'd0);
    tick();
    check("pulse_pend_10cyc", {24'd0, p_pend}, 32'h02);
    p_sig = '0;
    tick();
    check("pulse_irq", {31'd0, p_irq}, 32'd1);
    check("pulse_id", {29'd0, p_id}, 32'd1);
    check("pulse_no_err", {24'd0, p_err}, 32'd0);
    p_ack = 1'b1; tick(); p_ack = 1'b0;
    check("pulse_ack_irq", {31'd0, p_irq}, 32'd0);
    check("pulse_ack_pend", {24'd0, p_pend}, 32'd0);
    tick();
    check("pulse_single_req", {31'd0, p_irq}, 32'd0);

    p_sig = 8'h04;
    for (int i = 0; i < 4; i++) tick();
    p_sig = '0;
    tick();
    check("pulse_short_err", {24'd0, p_err}, 32'h04);
    tick(); tick(); tick();
    check("pulse_short_noirq", {31'd0, p_irq}, 32'd0);
    check("pulse_short_nopend", {24'd0, p_pend}, 32'd0);

    // 9 high cycles is one short; its error lands in the same cycle as err_clr
    p_sig = 8'h08;
    for (int i = 0; i < 9; i++) tick();
    p_sig = '0; p_errclr = 1'b1;
    tick();
    p_errclr = 1'b0;
    check("pulse_err_wins_clr", {24'd0, p_err}, 32'h08);
    check("pulse_9cyc_nopend", {24'd0, p_pend}, 32'd0);
    p_errclr = 1'b1; tick(); p_errclr = 1'b0;
    check("pulse_err_clr", {24'd0, p_err}, 32'd0);

    // Level mode
    l_sig = 8'h01;
    tick();
    check("lvl_pend", {24'd0, l_pend}, 32'h01);
    tick();
    check("lvl_irq", {31'd0, l_irq}, 32'd1);
    check("lvl_id0", {29'd0, l_id}, 32'd0);
    l_ack = 1'b1; tick(); l_ack = 1'b0;
    check("lvl_ack_irq", {31'd0, l_irq}, 32'd0);
    check("lvl_ack_keeps_pend", {24'd0, l_pend}, 32'h01);
    l_sig = 8'h41;
    tick(); tick(); tick();
    check("lvl_wait_noirq", {31'd0, l_irq}, 32'd0);
    check("lvl_wait_pend", {24'd0, l_pend}, 32'h41);
    l_sig = 8'h40;
    wait_lvl_irq(6, ok);
    check("lvl_src6_req", {31'd0, ok}, 32'd1);
    check("lvl_id6", {29'd0, l_id}, 32'd6);
    l_ack = 1'b1; tick(); l_ack = 1'b0;
    check("lvl_ack6_irq", {31'd0, l_irq}, 32'd0);
    l_sig = 8'h01;
    wait_lvl_irq(6, ok);
    check("lvl_src0_again", {31'd0, ok}, 32'd1);
    check("lvl_id0_again", {29'd0, l_id}, 32'd0);

    // Reset in the middle of an edge-mode request
    e_sig = 8'h01; tick(); e_sig = '0; tick();
    check("rst_pre_irq", {31'd0, e_irq}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst_mid_irq", {31'd0, e_irq}, 32'd0);
    check("rst_mid_id", {29'd0, e_id}, 32'd0);
    check("rst_mid_pend", {24'd0, e_pend}, 32'd0);
    e_ack = 1'b1; tick(); e_ack = 1'b0;
    check("rst_stray_ack", {31'd0, e_irq}, 32'd0);
    e_sig = 8'h02; tick(); e_sig = '0; tick();
    check("rst_fresh_irq", {31'd0, e_irq}, 32'd1);
    check("rst_fresh_id", {29'd0, e_id}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
